cond_unit_pipe: RTL and testbench
=================================

Name: cond_unit_pipe

Overview:
Multi-context, pipelined successor to the single-cycle conditional-execution logic. It holds NCTX banks of NZCV flags, evaluates the ARM condition field in Execute against the bank selected per instruction, and gates flag, register, memory and PC writes. It registers the gated write enables into Memory with stall/flush control, supports privileged flag save/restore, flags undefined condition codes, and keeps a saturating count of condition-failed instructions.

Parameters:
NCTX, 2, number of flag contexts (≥1)
CTXW, $clog2(NCTX) (min 1), context index width
CNTW, 16, width of the condition-fail counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
ValidE  in  1  Execute holds a real instruction
StallE  in  1  hold Execute and Memory this cycle
FlushE  in  1  squash the Execute instruction
CondE  in  4  condition field
CtxE  in  CTXW  flag context of the Execute instruction
ALUFlagsE  in  4  {N,Z,C,V} from ALU
FlagWE  in  2  [1] = write NZ, [0] = write CV
PCSE, RegWE, MemWE, NoWriteE  in  1 each  decoder requests
FlagLd  in  1  restore one flag bank
FlagLdCtx  in  CTXW  bank to restore
FlagLdData  in  4  restore value
FlagRdCtx  in  CTXW  bank to read
FlagRd  out  4  flags of bank FlagRdCtx (combinational)
CntClr  in  1  synchronous clear of the fail counter
CondExE  out  1  condition passed (combinational)
PCSrcE  out  1  branch redirect (combinational)
RegWriteM, MemWriteM, UndefM  out  1 each  registered Memory-stage enables
FailCount  out  CNTW  condition-failed instruction count

Behaviour:
- Reset (reset=0, async): all flag banks = 4'b0000; RegWriteM, MemWriteM, UndefM = 0; FailCount = 0.
- Condition codes, evaluated against Flags[CtxE]:
  - EQ/NE/CS/CC/MI/PL/VS/VC/HI/LS/GE/LT/GT/LE/AL = 0000..1110, standard ARM meanings; GE means N==V.
  - 1111 is undefined: CondExE = 0 and UndefE = 1.
- Active instruction: act = ValidE & ~FlushE & ~StallE. Pass: pass = act & CondExE.
- PCSrcE = pass & PCSE. It is combinational with zero latency and is never asserted when stalled or flushed.
- Flag update at the clock edge when pass:
  - FlagWE[1] writes Flags[CtxE][3:2].
  - FlagWE[0] writes Flags[CtxE][1:0].
  - A bit group that is not written holds its value.
  - The next instruction sees the updated flags one cycle later; no combinational forwarding is provided.
- Restore: when FlagLd=1, Flags[FlagLdCtx] <= FlagLdData regardless of stall or flush.
  - If FlagLdCtx == CtxE in the same cycle as an ALU flag write, FlagLd wins on all 4 bits.
  - Writes to different banks both take effect.
- Memory register, one cycle latency:
  - StallE=1 & FlushE=0: hold all M outputs.
  - FlushE=1 (priority over stall): M outputs <= 0 (bubble).
  - Otherwise:
    - RegWriteM <= pass & RegWE & ~NoWriteE
    - MemWriteM <= pass & MemWE
    - UndefM <= act & UndefE
- FailCount:
  - Increments by 1 per cycle where act & ~CondExE & ~UndefE.
  - Saturates at 2^CNTW-1.
  - CntClr=1 forces 0 and has priority over increment.
- FlagRd = Flags[FlagRdCtx]. It reflects the post-edge value the cycle after a write.
- Out-of-range context index (NCTX not a power of 2): reads return 0, writes are ignored.
- Reset asserted mid-operation clears everything immediately. The first instruction after reset sees all-zero flags: EQ fails, NE passes.

Test Plan:
- Reset, then CondE=0000 (EQ), ValidE=1, CtxE=0 → CondExE=0, FailCount=1 after the edge. CondE=0001 → CondExE=1.
- CtxE=0, CondE=1110, ALUFlagsE=0100, FlagWE=11 → Flags[0]=0100 at next edge, FlagRd(ctx1)=0000. Next cycle CtxE=0 EQ passes; CtxE=1 EQ fails.
- FlagWE=10 with ALUFlagsE=1111 over Flags[0]=0000 → Flags[0]=1100 (CV untouched). Then GE evaluates: N=1, V=0, so GE fails and LT passes.
- RegWE=1, NoWriteE=0, CondE=AL, StallE=1 for 2 cycles, then released → RegWriteM holds its prior 0 during the stall and becomes 1 one cycle after release. FlushE=1 with StallE=1 → RegWriteM=0 and no flag write.
- FlagLd=1, FlagLdCtx=0, FlagLdData=0010 simultaneous with ALU write of 1000 to ctx 0 → Flags[0]=0010. Concurrent ALU write to ctx 1 → Flags[1]=1000.
- CondE=1111, ValidE=1 → CondExE=0, PCSrcE=0, UndefM=1 next cycle, FailCount unchanged. With CNTW=2, 5 failing instructions → FailCount=3; CntClr during an increment cycle → 0.

Source files
------------

// File: rtl/cond_unit_pipe.sv
// cond_unit_pipe
//   Multi-context, pipelined conditional-execution unit. Keeps NCTX banks of
//   NZCV flags and evaluates the ARM condition field in Execute against the
//   bank named by CtxE. It gates flag, register, memory and PC writes, then
//   registers the gated enables into Memory with stall/flush control. It also
//   provides privileged flag save/restore and flags undefined condition
//   codes. A saturating counter tracks condition-failed instructions.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   ValidE/StallE/FlushE  Execute qualifiers
//   CondE, CtxE       condition field and flag context of the Execute instr
//   ALUFlagsE, FlagWE ALU {N,Z,C,V} and group write enables ([1]=NZ, [0]=CV)
//   PCSE/RegWE/MemWE/NoWriteE  decoder requests
//   FlagLd/FlagLdCtx/FlagLdData  privileged bank restore
//   FlagRdCtx, FlagRd bank read port (combinational)
//   CntClr            synchronous clear of FailCount
//   CondExE, PCSrcE   combinational Execute results
//   RegWriteM/MemWriteM/UndefM  registered Memory-stage enables
//   FailCount         saturating condition-fail count
module cond_unit_pipe #(
  parameter int unsigned NCTX = 2,
  parameter int unsigned CTXW = (NCTX > 1) ? $clog2(NCTX) : 1,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ValidE,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic [3:0]      CondE,
  input  logic [CTXW-1:0] CtxE,
  input  logic [3:0]      ALUFlagsE,
  input  logic [1:0]      FlagWE,
  input  logic            PCSE,
  input  logic            RegWE,
  input  logic            MemWE,
  input  logic            NoWriteE,
  input  logic            FlagLd,
  input  logic [CTXW-1:0] FlagLdCtx,
  input  logic [3:0]      FlagLdData,
  input  logic [CTXW-1:0] FlagRdCtx,
  output logic [3:0]      FlagRd,
  input  logic            CntClr,
  output logic            CondExE,
  output logic            PCSrcE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            UndefM,
  output logic [CNTW-1:0] FailCount
);

  typedef enum logic [3:0] {
    C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
    C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7,
    C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB,
    C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF
  } cond_e;

  logic [3:0]      r_flags [NCTX];
  logic [CNTW-1:0] r_fail_cnt;
  logic            r_reg_write_m;
  logic            r_mem_write_m;
  logic            r_undef_m;

  logic [3:0]      w_flags_e;
  logic            w_n, w_z, w_c, w_v;
  logic            w_cond_ok;
  logic            w_undef_e;
  logic            w_act;
  logic            w_pass;
  logic            w_fail;

  // Bank selection by comparison rather than direct indexing, so that an
  // out-of-range context (NCTX not a power of 2) reads as zero.
  always_comb begin
    w_flags_e = '0;
    FlagRd    = '0;
    for (int unsigned i = 0; i < NCTX; i++) begin
      if (CtxE == CTXW'(i))      w_flags_e = r_flags[i];
      if (FlagRdCtx == CTXW'(i)) FlagRd    = r_flags[i];
    end
  end

  assign {w_n, w_z, w_c, w_v} = w_flags_e;

  always_comb begin
    w_cond_ok = 1'b0;
    case (cond_e'(CondE))
      C_EQ:    w_cond_ok = w_z;
      C_NE:    w_cond_ok = ~w_z;
      C_CS:    w_cond_ok = w_c;
      C_CC:    w_cond_ok = ~w_c;
      C_MI:    w_cond_ok = w_n;
      C_PL:    w_cond_ok = ~w_n;
      C_VS:    w_cond_ok = w_v;
      C_VC:    w_cond_ok = ~w_v;
      C_HI:    w_cond_ok = w_c & ~w_z;
      C_LS:    w_cond_ok = ~w_c | w_z;
      C_GE:    w_cond_ok = (w_n == w_v);
      C_LT:    w_cond_ok = (w_n != w_v);
      C_GT:    w_cond_ok = ~w_z & (w_n == w_v);
      C_LE:    w_cond_ok = w_z | (w_n != w_v);
      C_AL:    w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  assign w_undef_e = (CondE == 4'b1111);
  assign CondExE   = w_cond_ok;
  assign w_act     = ValidE & ~FlushE & ~StallE;
  assign w_pass    = w_act & w_cond_ok;
  assign w_fail    = w_act & ~w_cond_ok & ~w_undef_e;
  assign PCSrcE    = w_pass & PCSE;

  // Restore takes all four bits of its bank and overrides an ALU write to
  // the same bank; writes to distinct banks proceed independently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NCTX; i++) r_flags[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NCTX; i++) begin
        if (FlagLd && (FlagLdCtx == CTXW'(i))) begin
          r_flags[i] <= FlagLdData;
        end else if (w_pass && (CtxE == CTXW'(i))) begin
          if (FlagWE[1]) r_flags[i][3:2] <= ALUFlagsE[3:2];
          if (FlagWE[0]) r_flags[i][1:0] <= ALUFlagsE[1:0];
        end
      end
    end
  end

  // Flush outranks stall: a flushed slot becomes a bubble even when held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reg_write_m <= 1'b0;
      r_mem_write_m <= 1'b0;
      r_undef_m     <= 1'b0;
    end else if (FlushE) begin
      r_reg_write_m <= 1'b0;
      r_mem_write_m <= 1'b0;
      r_undef_m     <= 1'b0;
    end else if (!StallE) begin
      r_reg_write_m <= w_pass & RegWE & ~NoWriteE;
      r_mem_write_m <= w_pass & MemWE;
      r_undef_m     <= w_act & w_undef_e;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fail_cnt <= '0;
    end else if (CntClr) begin
      r_fail_cnt <= '0;
    end else if (w_fail && (r_fail_cnt != '1)) begin
      r_fail_cnt <= r_fail_cnt + 1'b1;
    end
  end

  assign RegWriteM = r_reg_write_m;
  assign MemWriteM = r_mem_write_m;
  assign UndefM    = r_undef_m;
  assign FailCount = r_fail_cnt;

endmodule

// File: tb/tb_cond_unit_pipe.sv
// Directed bench for cond_unit_pipe. A second instance with a 2-bit fail
// counter shares the stimulus so saturation is reachable in a few cycles.
module tb_cond_unit_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        ValidE, StallE, FlushE;
  logic [3:0]  CondE;
  logic [0:0]  CtxE;
  logic [3:0]  ALUFlagsE;
  logic [1:0]  FlagWE;
  logic        PCSE, RegWE, MemWE, NoWriteE;
  logic        FlagLd;
  logic [0:0]  FlagLdCtx;
  logic [3:0]  FlagLdData;
  logic [0:0]  FlagRdCtx;
  logic        CntClr;

  logic [3:0]  FlagRd, s_FlagRd;
  logic        CondExE, s_CondExE;
  logic        PCSrcE, s_PCSrcE;
  logic        RegWriteM, s_RegWriteM;
  logic        MemWriteM, s_MemWriteM;
  logic        UndefM, s_UndefM;
  logic [15:0] FailCount;
  logic [1:0]  s_FailCount;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cond_unit_pipe u_dut (
    .clk(clk), .reset(reset), .ValidE(ValidE), .StallE(StallE), .FlushE(FlushE),
    .CondE(CondE), .CtxE(CtxE), .ALUFlagsE(ALUFlagsE), .FlagWE(FlagWE),
    .PCSE(PCSE), .RegWE(RegWE), .MemWE(MemWE), .NoWriteE(NoWriteE),
    .FlagLd(FlagLd), .FlagLdCtx(FlagLdCtx), .FlagLdData(FlagLdData),
    .FlagRdCtx(FlagRdCtx), .FlagRd(FlagRd), .CntClr(CntClr),
    .CondExE(CondExE), .PCSrcE(PCSrcE), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .UndefM(UndefM), .FailCount(FailCount)
  );

  cond_unit_pipe #(.CNTW(2)) u_small (
    .clk(clk), .reset(reset), .ValidE(ValidE), .StallE(StallE), .FlushE(FlushE),
    .CondE(CondE), .CtxE(CtxE), .ALUFlagsE(ALUFlagsE), .FlagWE(FlagWE),
    .PCSE(PCSE), .RegWE(RegWE), .MemWE(MemWE), .NoWriteE(NoWriteE),
    .FlagLd(FlagLd), .FlagLdCtx(FlagLdCtx), .FlagLdData(FlagLdData),
    .FlagRdCtx(FlagRdCtx), .FlagRd(s_FlagRd), .CntClr(CntClr),
    .CondExE(s_CondExE), .PCSrcE(s_PCSrcE), .RegWriteM(s_RegWriteM),
    .MemWriteM(s_MemWriteM), .UndefM(s_UndefM), .FailCount(s_FailCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    ValidE = 0; StallE = 0; FlushE = 0; CondE = 4'hE; CtxE = 0;
    ALUFlagsE = 0; FlagWE = 0; PCSE = 0; RegWE = 0; MemWE = 0; NoWriteE = 0;
    FlagLd = 0; FlagLdCtx = 0; FlagLdData = 0; FlagRdCtx = 0; CntClr = 0;

    // Reset state
    tick; tick;
    chk("rst_flag0", FlagRd, 4'h0);
    chk("rst_regw", RegWriteM, 1'b0);
    chk("rst_memw", MemWriteM, 1'b0);
    chk("rst_undef", UndefM, 1'b0);
    chk("rst_cnt", FailCount, 16'd0);
    reset = 1'b1;

    // EQ fails on zero flags and is counted; NE passes
    ValidE = 1; CtxE = 0; CondE = 4'h0; PCSE = 1;
    #1;
    chk("eq_zero_cond", CondExE, 1'b0);
    chk("eq_zero_pcsrc", PCSrcE, 1'b0);
    tick;
    chk("eq_fail_cnt", FailCount, 16'd1);
    CondE = 4'h1;
    #1;
    chk("ne_zero_cond", CondExE, 1'b1);
    chk("ne_zero_pcsrc", PCSrcE, 1'b1);
    tick;
    chk("ne_pass_cnt", FailCount, 16'd1);

    // ALU write of Z into ctx0 only
    PCSE = 0; CondE = 4'hE; ALUFlagsE = 4'b0100; FlagWE = 2'b11;
    tick;
    FlagWE = 0;
    FlagRdCtx = 0; #1;
    chk("z_wr_ctx0", FlagRd, 4'b0100);
    FlagRdCtx = 1; #1;
    chk("z_wr_ctx1", FlagRd, 4'b0000);
    CondE = 4'h0; CtxE = 0; #1;
    chk("eq_ctx0", CondExE, 1'b1);
    CtxE = 1; #1;
    chk("eq_ctx1", CondExE, 1'b0);

    // NZ-only write: CV must be preserved
    ValidE = 0; CtxE = 0; FlagLd = 1; FlagLdCtx = 0; FlagLdData = 4'b0000;
    tick;
    FlagLd = 0;
    ValidE = 1; CondE = 4'hE; ALUFlagsE = 4'b1111; FlagWE = 2'b10;
    tick;
    FlagWE = 0; FlagRdCtx = 0; #1;
    chk("nz_only_wr", FlagRd, 4'b1100);
    CondE = 4'hA; #1;
    chk("ge_n1v0", CondExE, 1'b0);
    CondE = 4'hB; #1;
    chk("lt_n1v0", CondExE, 1'b1);

    // Stall holds M stage, release writes one cycle later
    CondE = 4'hE; RegWE = 1; NoWriteE = 0; StallE = 1; PCSE = 1;
    #1;
    chk("stall_pcsrc", PCSrcE, 1'b0);
    tick;
    chk("stall_regw1", RegWriteM, 1'b0);
    tick;
    chk("stall_regw2", RegWriteM, 1'b0);
    StallE = 0; #1;
    chk("release_pcsrc", PCSrcE, 1'b1);
    tick;
    chk("release_regw", RegWriteM, 1'b1);
    PCSE = 0;

    // Flush with stall: bubble and no flag write
    FlushE = 1; StallE = 1; FlagWE = 2'b11; ALUFlagsE = 4'b0000;
    tick;
    chk("flush_regw", RegWriteM, 1'b0);
    chk("flush_flags", FlagRd, 4'b1100);
    FlushE = 0; StallE = 0; FlagWE = 0;

    // NoWriteE suppresses register write but not memory write
    RegWE = 1; NoWriteE = 1; MemWE = 1;
    tick;
    chk("nowrite_regw", RegWriteM, 1'b0);
    chk("nowrite_memw", MemWriteM, 1'b1);
    RegWE = 0; NoWriteE = 0; MemWE = 0;

    // Restore beats ALU write on the same bank
    CtxE = 0; ALUFlagsE = 4'b1000; FlagWE = 2'b11;
    FlagLd = 1; FlagLdCtx = 0; FlagLdData = 4'b0010;
    tick;
    chk("ld_wins", FlagRd, 4'b0010);
    chk("ld_wins_memw", MemWriteM, 1'b0);
    // Restore and ALU write on different banks both land
    CtxE = 1; FlagLdData = 4'b0110;
    tick;
    FlagLd = 0; FlagWE = 0;
    FlagRdCtx = 1; #1;
    chk("split_ctx1", FlagRd, 4'b1000);
    FlagRdCtx = 0; #1;
    chk("split_ctx0", FlagRd, 4'b0110);

    // Undefined condition
    CtxE = 0; CondE = 4'hF; PCSE = 1; #1;
    chk("nv_cond", CondExE, 1'b0);
    chk("nv_pcsrc", PCSrcE, 1'b0);
    tick;
    chk("nv_undefm", UndefM, 1'b1);
    chk("nv_cnt", FailCount, 16'd1);
    chk("nv_cnt_small", s_FailCount, 2'd1);
    PCSE = 0; CondE = 4'hE;
    tick;
    chk("undef_clear", UndefM, 1'b0);

    // Counter saturation on the 2-bit instance, then clear priority
    ValidE = 0; CntClr = 1;
    tick;
    CntClr = 0;
    chk("clr_cnt", FailCount, 16'd0);
    ValidE = 1; CondE = 4'h1; #1;   // Z=1 in ctx0 so NE fails
    chk("ne_z1", CondExE, 1'b0);
    repeat (5) tick;
    chk("five_fail_cnt", FailCount, 16'd5);
    chk("sat_small", s_FailCount, 2'd3);
    CntClr = 1;
    tick;
    chk("clr_over_inc", FailCount, 16'd0);
    chk("clr_over_inc_s", s_FailCount, 2'd0);
    CntClr = 0;
    tick;
    chk("inc_after_clr", FailCount, 16'd1);

    // Asynchronous reset mid-operation
    reset = 1'b0; #1;
    chk("async_flags", FlagRd, 4'h0);
    chk("async_cnt", FailCount, 16'd0);
    chk("async_cnt_s", s_FailCount, 2'd0);
    reset = 1'b1;
    CtxE = 0; CondE = 4'h0; #1;
    chk("post_rst_eq", CondExE, 1'b0);
    CondE = 4'h1; #1;
    chk("post_rst_ne", CondExE, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
